// File: rtl/restoring_divider_8bit.sv
// rtl/restoring_divider_8bit.sv - sequential 8-bit unsigned restoring divider with Run-button control
module restoring_divider_8bit (
   input  logic       Clk,
   input  logic       Reset_Load_Clear,
   input  logic       Run,
   input  logic [7:0] Dividend,
   input  logic [7:0] Divisor,
   output logic [7:0] Quotient,
   output logic [7:0] Remainder,
   output logic       Busy,
   output logic       Done,
   output logic       Div_By_Zero
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_SHIFT = 3'd2,
      S_TEST  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t     state, state_next;
   logic [7:0] nq, dr;
   logic [8:0] r;
   logic [2:0] cnt;
   logic [8:0] diff;
   logic [8:0] r_test;
   logic [7:0] nq_test;

   // A clear borrow means the divisor fits: keep the difference and set the quotient bit.
   assign diff    = r - {1'b0, dr};
   assign r_test  = diff[8] ? r : diff;
   assign nq_test = diff[8] ? nq : {nq[7:1], 1'b1};

   always_ff @(posedge Clk) begin
      if (Reset_Load_Clear)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (Run) state_next = S_ARM;
         S_ARM:   if (!Run) state_next = (dr == 8'd0) ? S_DONE : S_SHIFT;
         S_SHIFT: state_next = S_TEST;
         S_TEST:  state_next = (cnt == 3'd7) ? S_DONE : S_SHIFT;
         S_DONE:  if (Run) state_next = S_ARM;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      case (state)
         S_SHIFT, S_TEST: Busy = 1'b1;
         S_DONE:          Done = 1'b1;
         default:         ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset_Load_Clear) begin
         nq          <= 8'd0;
         dr          <= 8'd0;
         r           <= 9'd0;
         cnt         <= 3'd0;
         Quotient    <= 8'd0;
         Remainder   <= 8'd0;
         Div_By_Zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (Run) begin
                  nq  <= Dividend;
                  dr  <= Divisor;
                  r   <= 9'd0;
                  cnt <= 3'd0;
               end
            end
            S_ARM: begin
               if (!Run && dr == 8'd0) begin
                  Quotient    <= 8'hFF;
                  Remainder   <= nq;
                  Div_By_Zero <= 1'b1;
               end
            end
            S_SHIFT: begin
               {r, nq} <= {r[7:0], nq, 1'b0};
            end
            S_TEST: begin
               r  <= r_test;
               nq <= nq_test;
               if (cnt == 3'd7) begin
                  Quotient    <= nq_test;
                  Remainder   <= r_test[7:0];
                  Div_By_Zero <= 1'b0;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// tb/tb_restoring_divider_8bit.sv - directed and random checks of the restoring divider against arithmetic
module tb_restoring_divider_8bit;

   logic       Clk = 1'b0;
   logic       Reset_Load_Clear;
   logic       Run;
   logic [7:0] Dividend, Divisor;
   logic [7:0] Quotient, Remainder;
   logic       Busy, Done, Div_By_Zero;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] prev_q = 8'd0;
   logic [7:0] prev_r = 8'd0;

   restoring_divider_8bit dut (
      .Clk(Clk),
      .Reset_Load_Clear(Reset_Load_Clear),
      .Run(Run),
      .Dividend(Dividend),
      .Divisor(Divisor),
      .Quotient(Quotient),
      .Remainder(Remainder),
      .Busy(Busy),
      .Done(Done),
      .Div_By_Zero(Div_By_Zero)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Run held for 'hold' cycles after capture; optional operand swap after capture.
   task automatic run_div(input logic [7:0] n, input logic [7:0] d, input int hold,
                          input bit alt_en, input logic [7:0] alt_n, input logic [7:0] alt_d);
      int busy_cnt;
      int done_at;
      logic [7:0] eq, er;
      logic ez;
      Dividend = n;
      Divisor  = d;
      Run      = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge Clk);
         if (alt_en) begin
            Dividend = alt_n;
            Divisor  = alt_d;
         end
         check("arm_done", Done, 0);
         check("arm_busy", Busy, 0);
         check("arm_q_held", Quotient, prev_q);
         check("arm_r_held", Remainder, prev_r);
      end
      Run = 1'b0;
      busy_cnt = 0;
      done_at  = 0;
      for (int k = 1; k <= 40 && done_at == 0; k++) begin
         @(negedge Clk);
         if (Busy === 1'b1) busy_cnt++;
         if (Done === 1'b1) done_at = k;
      end
      if (d == 8'd0) begin
         eq = 8'hFF;
         er = n;
         ez = 1'b1;
      end else begin
         eq = n / d;
         er = n % d;
         ez = 1'b0;
      end
      check("busy_cycles", busy_cnt, (d == 8'd0) ? 0 : 16);
      check("done_latency", done_at, (d == 8'd0) ? 1 : 17);
      check("quotient", Quotient, eq);
      check("remainder", Remainder, er);
      check("div_by_zero", Div_By_Zero, ez);
      prev_q = eq;
      prev_r = er;
   endtask

   initial begin
      Reset_Load_Clear = 1'b1;
      Run      = 1'b0;
      Dividend = 8'd0;
      Divisor  = 8'd0;
      @(negedge Clk);
      @(negedge Clk);
      Reset_Load_Clear = 1'b0;
      check("rst_q", Quotient, 0);
      check("rst_r", Remainder, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_dbz", Div_By_Zero, 0);

      run_div(8'd200, 8'd7, 3, 1'b0, 8'd0, 8'd0);
      run_div(8'd255, 8'd1, 1, 1'b0, 8'd0, 8'd0);
      run_div(8'd5, 8'd9, 1, 1'b0, 8'd0, 8'd0);
      run_div(8'd255, 8'd255, 1, 1'b0, 8'd0, 8'd0);
      run_div(8'd100, 8'd0, 2, 1'b0, 8'd0, 8'd0);
      run_div(8'd144, 8'd12, 1, 1'b0, 8'd0, 8'd0);
      run_div(8'd50, 8'd6, 2, 1'b1, 8'd9, 8'd3);
      check("captured_q", Quotient, 8);
      check("captured_r", Remainder, 2);

      // Reset during the 5th TEST cycle of 200/7.
      Dividend = 8'd200;
      Divisor  = 8'd7;
      Run      = 1'b1;
      @(negedge Clk);
      Run = 1'b0;
      for (int k = 1; k <= 10; k++) @(negedge Clk);
      check("mid_busy", Busy, 1);
      Reset_Load_Clear = 1'b1;
      @(negedge Clk);
      Reset_Load_Clear = 1'b0;
      check("mid_rst_q", Quotient, 0);
      check("mid_rst_r", Remainder, 0);
      check("mid_rst_busy", Busy, 0);
      check("mid_rst_done", Done, 0);
      check("mid_rst_dbz", Div_By_Zero, 0);
      @(negedge Clk);
      check("idle_busy", Busy, 0);
      check("idle_done", Done, 0);
      prev_q = 8'd0;
      prev_r = 8'd0;
      run_div(8'd200, 8'd7, 1, 1'b0, 8'd0, 8'd0);

      // Run held in DONE for 10 cycles, then released.
      run_div(8'd77, 8'd5, 10, 1'b0, 8'd0, 8'd0);

      for (int i = 0; i < 24; i++) begin
         logic [7:0] rn, rd;
         rn = 8'($urandom);
         rd = (i % 6 == 5) ? 8'd0 : 8'($urandom_range(1, 255));
         if (i % 4 == 3) rd = 8'($urandom_range(1, 15));
         run_div(rn, rd, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/restoring_divider_8bit.md
# restoring_divider_8bit

Sequential 8-bit unsigned divider, the inverse-operation companion to the shift-add multiplier datapath. It uses the same board-level control style: a Run button press captures the operands, and releasing the button starts the computation. The quotient and remainder are produced by restoring division, one bit per two-cycle shift/test iteration, and then held for display until the next Run press.

## Interface
Parameters:
- none (width fixed at 8)

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset_Load_Clear  in  1  one clock; reset is synchronous and active-high
- Run  in  1  start button, level, active-high, already debounced/synchronized upstream
- Dividend  in  8  unsigned dividend N
- Divisor  in  8  unsigned divisor D
- Quotient  out  8  registered result N / D
- Remainder  out  8  registered result N mod D
- Busy  out  1  high while in SHIFT or TEST
- Done  out  1  high in DONE; results valid
- Div_By_Zero  out  1  high in DONE when the captured D was 0

## Operation
- Internal registers:
  - Nq (8b): dividend/quotient shift register
  - Dr (8b): captured divisor
  - R (9b): partial remainder
  - cnt (3b): iteration counter
  - result registers driving Quotient, Remainder, Div_By_Zero
- States: IDLE, ARM, SHIFT, TEST, DONE.
- IDLE: all outputs 0.
  - Run=1 → ARM; Nq←Dividend, Dr←Divisor, R←0, cnt←0.
- ARM: waits for button release; operand changes are ignored.
  - Run=1 → stay in ARM.
  - Run=0 and Dr≠0 → SHIFT.
  - Run=0 and Dr=0 → DONE, with result registers loaded as Quotient=8'hFF, Remainder=Nq, Div_By_Zero=1.
- SHIFT: {R,Nq} ← {R,Nq} << 1 (R[0] gets Nq[7], Nq[0] gets 0). Next state is TEST.
- TEST: diff = R − {1'b0,Dr}, computed at 9 bits.
  - If diff[8]=0: R←diff and Nq[0]←1; otherwise R and Nq are unchanged (bit stays 0).
  - If cnt=7: go to DONE. On that same edge, load Quotient with the updated Nq and Remainder with the updated R[7:0], and set Div_By_Zero=0.
  - Otherwise cnt←cnt+1 and go to SHIFT.
- DONE: Done=1 and results are held indefinitely.
  - Run=1 → ARM, capturing new operands as in IDLE. Done drops in the ARM cycle.
  - Result outputs keep their previous values until the next DONE load.
- Run is ignored in SHIFT and TEST. There is no abort except reset.
- Invariant: R never exceeds Dr after a TEST, so R[8] is 0 at the DONE load.

## Timing
- Reset_Load_Clear sampled high at any edge, in any state: at the next cycle the state is IDLE and Quotient=0, Remainder=0, Busy=0, Done=0, Div_By_Zero=0. Reset has priority over Run.
- Let t be the cycle in which the state is ARM and Run=0.
- Normal division:
  - SHIFT/TEST alternate during cycles t+1 … t+16.
  - Busy is high for those 16 cycles.
  - DONE is entered at t+17, and Quotient/Remainder are valid in that same cycle.
- Divide by zero: DONE is entered at t+1 and Busy never asserts.
- Operands are captured only on the edge that enters ARM. A Run pulse of one cycle is legal: ARM is entered, then Run=0 gives t = the ARM cycle.
- Back-to-back operations: Run=1 in DONE → ARM on the next cycle. There is no dead cycle.

## Test plan
- Reset, then N=200, D=7, Run high 3 cycles then low → Busy high exactly 16 cycles; Done asserts 17 cycles after the first ARM cycle with Run=0; Quotient=28, Remainder=4, Div_By_Zero=0.
- N=255, D=1 → Q=255, R=0. Then N=5, D=9 → Q=0, R=5. Then N=255, D=255 → Q=1, R=0.
- N=100, D=0 → Busy never high; DONE one cycle after release with Q=8'hFF, R=100, Div_By_Zero=1. A following N=144, D=12 gives Q=12, R=0, Div_By_Zero=0.
- Operands changed while in ARM and during SHIFT/TEST (start N=50, D=6, then switch to N=9, D=3) → result uses the captured values: Q=8, R=2.
- Reset_Load_Clear asserted during the 5th TEST cycle of 200/7 → next cycle IDLE with all outputs 0. A new 200/7 run then completes normally with Q=28, R=4.
- Run held in DONE for 10 cycles → stays in ARM with Done=0 and Quotient/Remainder unchanged; computation begins only after release.
